// File: rtl/tpu_pkg.sv
// Shared NPU types: instruction word, opcode classes and scheduler states.
// The scheduler decodes only the opcode; the remaining fields pass through untouched.
package tpu_pkg;

  typedef struct packed {
    logic [7:0]  op_code;
    logic [31:0] calc_length;
    logic [15:0] acc_address;
    logic [23:0] buffer_address;
  } instruction_t;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_WEIGHT,
    CLS_MATMUL,
    CLS_ACTIVATE,
    CLS_SYNC
  } inst_class_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT_ISSUE,
    S_SYNC_DRAIN,
    S_SYNC_DONE
  } sched_state_t;

  localparam logic [7:0] OPC_SYNC = 8'hFF;
  localparam logic [7:0] OPC_NOP  = 8'h00;
  localparam int OPC_ACT_BIT = 7;
  localparam int OPC_MMU_BIT = 5;
  localparam int OPC_WEI_BIT = 3;

  // Exact SYNC/NOP codes are tested before the class bits, so 0xFF never decodes as ACTIVATE.
  function automatic inst_class_t opcode_class(input logic [7:0] op);
    inst_class_t cls;
    if (op == OPC_SYNC)          cls = CLS_SYNC;
    else if (op == OPC_NOP)      cls = CLS_NOP;
    else if (op[OPC_ACT_BIT])    cls = CLS_ACTIVATE;
    else if (op[OPC_MMU_BIT])    cls = CLS_MATMUL;
    else if (op[OPC_WEI_BIT])    cls = CLS_WEIGHT;
    else                         cls = CLS_NOP;
    return cls;
  endfunction

endpackage

// File: rtl/cellrv32_npu_hazard_check.sv
// Combinational issue-permission check for the held instruction class.
// SYNC is treated as "issuable" once every unit and its pipeline have drained.
module cellrv32_npu_hazard_check
  import tpu_pkg::*;
(
  input  inst_class_t cls,
  input  logic        wei_busy,
  input  logic        mmu_busy,
  input  logic        act_busy,
  input  logic        wei_res_busy,
  input  logic        mmu_res_busy,
  input  logic        act_res_busy,
  input  logic        wei_pending,
  output logic        issue_ok
);

  always_comb begin
    issue_ok = 1'b0;
    case (cls)
      CLS_WEIGHT:   issue_ok = !wei_busy;
      // A pending weight load must finish before the multiply consumes it.
      CLS_MATMUL:   issue_ok = !mmu_busy && !(wei_pending && wei_busy);
      CLS_ACTIVATE: issue_ok = !act_busy && !mmu_res_busy;
      CLS_SYNC:     issue_ok = !(wei_busy || mmu_busy || act_busy ||
                                 wei_res_busy || mmu_res_busy || act_res_busy);
      default:      issue_ok = 1'b1;
    endcase
  end

endmodule

// File: rtl/cellrv32_npu_inst_scheduler.sv
// In-order NPU issue stage: captures one instruction, waits for its target unit's
// hazards to clear, then strobes that unit with the instruction on a registered bus.
//
// state        | meaning
// S_IDLE       | ready for a new instruction from the FIFO
// S_WAIT_ISSUE | unit instruction held, waiting for hazard clearance
// S_SYNC_DRAIN | SYNC accepted, waiting for all units to go idle
// S_SYNC_DONE  | drain complete, synchronize_o pulses this cycle
module cellrv32_npu_inst_scheduler
  import tpu_pkg::*;
#(
  parameter int unsigned MATRIX_WIDTH    = 14,
  parameter int unsigned ISSUE_CNT_WIDTH = 32
) (
  input  logic                       clk_i,
  input  logic                       rstn_i,
  input  logic                       enable_i,
  input  instruction_t               inst_i,
  input  logic                       inst_valid_i,
  output logic                       inst_ready_o,
  output instruction_t               inst_o,
  output logic                       wei_en_o,
  output logic                       mmu_en_o,
  output logic                       act_en_o,
  input  logic                       wei_busy_i,
  input  logic                       mmu_busy_i,
  input  logic                       act_busy_i,
  input  logic                       wei_res_busy_i,
  input  logic                       mmu_res_busy_i,
  input  logic                       act_res_busy_i,
  output logic                       synchronize_o,
  output logic                       busy_o,
  output logic [ISSUE_CNT_WIDTH-1:0] retired_cnt_o,
  output logic [ISSUE_CNT_WIDTH-1:0] stall_cnt_o
);

  sched_state_t                state_q, state_d;
  instruction_t                hold_q;
  inst_class_t                 hold_cls_q;
  logic                        hold_valid_q;
  logic                        wei_pending_q;
  logic                        wei_en_q, mmu_en_q, act_en_q;
  instruction_t                inst_q;
  logic [ISSUE_CNT_WIDTH-1:0]  retired_q, stall_q;

  logic        handshake;
  inst_class_t in_cls;
  logic        issue_ok;
  logic        issue, retire, stall;

  assign in_cls       = opcode_class(inst_i.op_code);
  assign inst_ready_o = enable_i && (state_q == S_IDLE) && !hold_valid_q;
  assign handshake    = inst_valid_i && inst_ready_o;

  // hold_cls_q is loaded for SYNC as well, so the drain check reuses the same path.
  cellrv32_npu_hazard_check u_hazard (
    .cls          (hold_cls_q),
    .wei_busy     (wei_busy_i),
    .mmu_busy     (mmu_busy_i),
    .act_busy     (act_busy_i),
    .wei_res_busy (wei_res_busy_i),
    .mmu_res_busy (mmu_res_busy_i),
    .act_res_busy (act_res_busy_i),
    .wei_pending  (wei_pending_q),
    .issue_ok     (issue_ok)
  );

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    retire  = 1'b0;
    stall   = 1'b0;
    if (enable_i) begin
      case (state_q)
        S_IDLE: begin
          if (handshake) state_d = (in_cls == CLS_SYNC) ? S_SYNC_DRAIN : S_WAIT_ISSUE;
        end
        S_WAIT_ISSUE: begin
          if (issue_ok) begin
            issue   = 1'b1;
            retire  = 1'b1;
            state_d = S_IDLE;
          end else begin
            stall = 1'b1;
          end
        end
        S_SYNC_DRAIN: begin
          if (issue_ok) state_d = S_SYNC_DONE;
          else          stall   = 1'b1;
        end
        S_SYNC_DONE: begin
          retire  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q       <= S_IDLE;
      hold_q        <= '0;
      hold_cls_q    <= CLS_NOP;
      hold_valid_q  <= 1'b0;
      wei_pending_q <= 1'b0;
      wei_en_q      <= 1'b0;
      mmu_en_q      <= 1'b0;
      act_en_q      <= 1'b0;
      inst_q        <= '0;
      retired_q     <= '0;
      stall_q       <= '0;
    end else if (enable_i) begin
      state_q  <= state_d;
      wei_en_q <= issue && (hold_cls_q == CLS_WEIGHT);
      mmu_en_q <= issue && (hold_cls_q == CLS_MATMUL);
      act_en_q <= issue && (hold_cls_q == CLS_ACTIVATE);
      if (handshake) begin
        hold_q       <= inst_i;
        hold_cls_q   <= in_cls;
        hold_valid_q <= (in_cls != CLS_SYNC);
      end
      if (issue) begin
        hold_valid_q <= 1'b0;
        if (hold_cls_q != CLS_NOP) inst_q <= hold_q;
        if (hold_cls_q == CLS_WEIGHT) wei_pending_q <= 1'b1;
        if (hold_cls_q == CLS_MATMUL) wei_pending_q <= 1'b0;
      end
      if (retire) retired_q <= retired_q + 1'b1;
      if (stall)  stall_q   <= stall_q + 1'b1;
    end else begin
      wei_en_q <= 1'b0;
      mmu_en_q <= 1'b0;
      act_en_q <= 1'b0;
    end
  end

  assign inst_o        = inst_q;
  assign wei_en_o      = wei_en_q;
  assign mmu_en_o      = mmu_en_q;
  assign act_en_o      = act_en_q;
  // Gated so a frozen SYNC_DONE state cannot stretch the pulse.
  assign synchronize_o = (state_q == S_SYNC_DONE) && enable_i;
  assign busy_o        = hold_valid_q || (state_q != S_IDLE);
  assign retired_cnt_o = retired_q;
  assign stall_cnt_o   = stall_q;

  a_one_strobe : assert property (@(posedge clk_i) disable iff (!rstn_i)
    (MATRIX_WIDTH > 0) && $onehot0({wei_en_o, mmu_en_o, act_en_o}));

endmodule

// File: tb/tb_cellrv32_npu_inst_scheduler.sv
// Directed bench for the NPU instruction scheduler with a strobe scoreboard.
module tb_cellrv32_npu_inst_scheduler;
  import tpu_pkg::*;

  logic         clk_i = 1'b0;
  logic         rstn_i;
  logic         enable_i;
  instruction_t inst_i;
  logic         inst_valid_i;
  logic         inst_ready_o;
  instruction_t inst_o;
  logic         wei_en_o, mmu_en_o, act_en_o;
  logic         wei_busy_i, mmu_busy_i, act_busy_i;
  logic         wei_res_busy_i, mmu_res_busy_i, act_res_busy_i;
  logic         synchronize_o, busy_o;
  logic [31:0]  retired_cnt_o, stall_cnt_o;

  cellrv32_npu_inst_scheduler #(.MATRIX_WIDTH(14), .ISSUE_CNT_WIDTH(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
    .inst_i(inst_i), .inst_valid_i(inst_valid_i), .inst_ready_o(inst_ready_o),
    .inst_o(inst_o), .wei_en_o(wei_en_o), .mmu_en_o(mmu_en_o), .act_en_o(act_en_o),
    .wei_busy_i(wei_busy_i), .mmu_busy_i(mmu_busy_i), .act_busy_i(act_busy_i),
    .wei_res_busy_i(wei_res_busy_i), .mmu_res_busy_i(mmu_res_busy_i),
    .act_res_busy_i(act_res_busy_i), .synchronize_o(synchronize_o), .busy_o(busy_o),
    .retired_cnt_o(retired_cnt_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // strobes = {sync, act, mmu, wei}
  typedef struct packed {
    logic [3:0]   strobes;
    instruction_t inst;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic instruction_t mk(input logic [7:0] op, input logic [31:0] len);
    instruction_t t;
    t.op_code        = op;
    t.calc_length    = len;
    t.acc_address    = {8'hA5, op};
    t.buffer_address = {op, 16'h3C00} ^ 24'h00_0F0F;
    return t;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Holds valid until the handshake edge; pushes the expected strobe (if any) first.
  task automatic send(input instruction_t t, input logic [3:0] strobes);
    int n;
    exp_t e;
    inst_i       = t;
    inst_valid_i = 1'b1;
    n = 0;
    while (!inst_ready_o && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) chk("handshake_timeout", 128'(inst_ready_o), 128'(1'b1));
    if (strobes != 4'b0000) begin
      e.strobes = strobes;
      e.inst    = t;
      sb.push_back(e);
    end
    tick();
    inst_valid_i = 1'b0;
  endtask

  // Monitor: every strobe the DUT emits must match the oldest outstanding expectation.
  always @(negedge clk_i) begin
    logic [3:0] seen;
    exp_t       e;
    seen = {synchronize_o, act_en_o, mmu_en_o, wei_en_o};
    if (rstn_i && seen != 4'b0000) begin
      if (sb.size() == 0) begin
        chk("unexpected_strobe", 128'(seen), 128'(4'b0000));
      end else begin
        e = sb.pop_front();
        chk("strobe_kind", 128'(seen), 128'(e.strobes));
        if (!seen[3]) chk("strobe_inst", 128'(inst_o), 128'(e.inst));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    instruction_t w1, m1, m2, a1, sy, w2, w3, m3;
    int s0, r0, n;

    rstn_i = 1'b0; enable_i = 1'b0; inst_i = '0; inst_valid_i = 1'b0;
    wei_busy_i = 0; mmu_busy_i = 0; act_busy_i = 0;
    wei_res_busy_i = 0; mmu_res_busy_i = 0; act_res_busy_i = 0;

    // Reset state
    tick(); tick();
    chk("rst_ready",   128'(inst_ready_o), 128'(0));
    chk("rst_inst",    128'(inst_o), 128'(0));
    chk("rst_strobes", 128'({synchronize_o, act_en_o, mmu_en_o, wei_en_o}), 128'(0));
    chk("rst_busy",    128'(busy_o), 128'(0));
    chk("rst_retired", 128'(retired_cnt_o), 128'(0));
    chk("rst_stall",   128'(stall_cnt_o), 128'(0));
    rstn_i = 1'b1;
    tick();
    enable_i = 1'b1;
    #1;
    chk("idle_ready", 128'(inst_ready_o), 128'(1));

    // WEIGHT, all units free: strobe in the cycle after the issue edge
    w1 = mk(8'h08, 32'h0000_1234);
    send(w1, 4'b0001);
    chk("w1_no_early_strobe", 128'(wei_en_o), 128'(0));
    chk("w1_busy",            128'(busy_o), 128'(1));
    chk("w1_not_ready",       128'(inst_ready_o), 128'(0));
    tick();
    chk("w1_strobe", 128'(wei_en_o), 128'(1));
    chk("w1_inst",   128'(inst_o), 128'(w1));
    tick();
    chk("w1_strobe_once", 128'(wei_en_o), 128'(0));
    chk("w1_retired",     128'(retired_cnt_o), 128'(1));
    chk("w1_idle",        128'(busy_o), 128'(0));

    // MATMUL behind a pending WEIGHT while the weight unit stays busy for 10 cycles
    wei_busy_i = 1'b1;
    m1 = mk(8'h20, 32'h0000_0040);
    send(m1, 4'b0010);
    s0 = stall_cnt_o;
    repeat (10) begin
      chk("m1_withheld", 128'(mmu_en_o), 128'(0));
      tick();
    end
    wei_busy_i = 1'b0;
    tick();
    chk("m1_strobe",    128'(mmu_en_o), 128'(1));
    chk("m1_inst",      128'(inst_o), 128'(m1));
    chk("m1_stall_cnt", 128'(stall_cnt_o - s0), 128'(10));
    tick();
    chk("m1_retired", 128'(retired_cnt_o), 128'(2));

    // ACTIVATE waits on accumulators still busy from the preceding MATMUL
    m2 = mk(8'h21, 32'h0000_0080);
    send(m2, 4'b0010);
    mmu_res_busy_i = 1'b1;
    a1 = mk(8'h80, 32'h0000_0010);
    send(a1, 4'b0100);
    s0 = stall_cnt_o;
    repeat (20) begin
      chk("a1_withheld", 128'(act_en_o), 128'(0));
      chk("a1_no_ready", 128'(inst_ready_o), 128'(0));
      tick();
    end
    mmu_res_busy_i = 1'b0;
    tick();
    chk("a1_strobe",    128'(act_en_o), 128'(1));
    chk("a1_stall_cnt", 128'(stall_cnt_o - s0), 128'(20));
    tick();
    chk("a1_retired", 128'(retired_cnt_o), 128'(4));

    // SYNC drains the activation pipeline before completing
    act_res_busy_i = 1'b1;
    r0 = retired_cnt_o;
    sy = mk(8'hFF, 32'h0);
    send(sy, 4'b1000);
    repeat (5) begin
      chk("sync_waiting", 128'({synchronize_o, act_en_o, mmu_en_o, wei_en_o}), 128'(0));
      tick();
    end
    act_res_busy_i = 1'b0;
    n = 0;
    while (!synchronize_o && n < 10) begin
      tick();
      n++;
    end
    chk("sync_pulse",       128'(synchronize_o), 128'(1));
    chk("sync_retired_pre", 128'(retired_cnt_o), 128'(r0));
    tick();
    chk("sync_pulse_once", 128'(synchronize_o), 128'(0));
    chk("sync_retired",    128'(retired_cnt_o), 128'(r0 + 1));
    chk("sync_idle",       128'(busy_o), 128'(0));

    // Four NOP-class opcodes back to back: retire every 2 cycles, no strobes
    r0 = retired_cnt_o;
    send(mk(8'h00, 32'h1), 4'b0000);
    send(mk(8'h00, 32'h2), 4'b0000);
    send(mk(8'h40, 32'h3), 4'b0000);
    send(mk(8'h04, 32'h4), 4'b0000);
    tick();
    chk("nop_retired", 128'(retired_cnt_o), 128'(r0 + 4));

    // Decode priority: bit7 beats bit5 beats bit3
    r0 = retired_cnt_o;
    send(mk(8'hA8, 32'h5), 4'b0100);
    send(mk(8'h28, 32'h6), 4'b0010);
    send(mk(8'h18, 32'h7), 4'b0001);
    tick();
    chk("prio_retired", 128'(retired_cnt_o), 128'(r0 + 3));

    // Global stall freezes a ready-to-issue WEIGHT
    w2 = mk(8'h0C, 32'hCAFE);
    send(w2, 4'b0001);
    enable_i = 1'b0;
    s0 = stall_cnt_o;
    repeat (3) begin
      chk("en_off_no_strobe", 128'(wei_en_o), 128'(0));
      chk("en_off_no_ready",  128'(inst_ready_o), 128'(0));
      tick();
    end
    chk("en_off_stall_frozen", 128'(stall_cnt_o), 128'(s0));
    enable_i = 1'b1;
    tick();
    chk("en_on_strobe", 128'(wei_en_o), 128'(1));
    tick();

    // Reset in the middle of a blocked MATMUL discards it
    mmu_busy_i = 1'b1;
    m3 = mk(8'h20, 32'hDEAD);
    send(m3, 4'b0010);
    repeat (3) begin
      chk("m3_blocked", 128'(mmu_en_o), 128'(0));
      tick();
    end
    rstn_i = 1'b0;
    sb.delete();
    #1;
    chk("midrst_busy",    128'(busy_o), 128'(0));
    chk("midrst_retired", 128'(retired_cnt_o), 128'(0));
    chk("midrst_stall",   128'(stall_cnt_o), 128'(0));
    chk("midrst_inst",    128'(inst_o), 128'(0));
    chk("midrst_strobes", 128'({synchronize_o, act_en_o, mmu_en_o, wei_en_o}), 128'(0));
    tick();
    rstn_i     = 1'b1;
    mmu_busy_i = 1'b0;
    tick(); tick();
    w3 = mk(8'h09, 32'h0BEE);
    send(w3, 4'b0001);
    tick();
    chk("post_rst_strobe", 128'(wei_en_o), 128'(1));
    chk("post_rst_inst",   128'(inst_o), 128'(w3));
    tick();
    chk("post_rst_retired", 128'(retired_cnt_o), 128'(1));

    tick(); tick();
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
